sram_rr_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for one single-port 1024x32 SRAM macro (active-low chip enable CEB, active-low write enable WEB, registered read data Q one cycle after a read edge). Two independent requesters issue reads or writes with a valid/ready handshake. The block issues at most one SRAM access per cycle, tracks read latency, and returns read data per port through a small response FIFO with its own valid/ready handshake.

---
 rtl/sram_rr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//
// Purpose:
//   Shares one single-port SRAM macro (active-low CEB/WEB, registered Q one
//   cycle after a read edge) between two requesters. At most one access is
//   issued per cycle. A two-way round-robin pointer breaks ties. Reads are
//   tracked with a one-entry in-flight tag, and their data is returned
//   through a small per-port response FIFO.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   reqN_valid/ready/we/addr/wdata request channel of requester N (ready is
//                                 combinational: it is the grant)
//   rspN_valid/ready/rdata        read response channel of requester N
//   sram_ceb/web/a/d              SRAM controls, driven combinationally from
//                                 the grant
//   sram_q                        SRAM read data, valid the cycle after a read
//                                 edge

module sram_rr_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    // Gather the two requester channels into arrays indexed by port.
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [1:0]        rsp_ready;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign req_we       = {req1_we, req0_we};
    assign rsp_ready    = {rsp1_ready, rsp0_ready};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    // Control state.
    logic             prio_q, prio_d;
    logic             tag_vld_q, tag_vld_d;
    logic             tag_port_q, tag_port_d;
    logic [CNT_W-1:0] occ_q    [2];
    logic [CNT_W-1:0] occ_d    [2];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];

    // Response storage (data only, never reset).
    logic [DATA_W-1:0] fifo_q [2][RSP_DEPTH];

    logic [1:0]       infl;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       rd_ok;
    logic [1:0]       elig;
    logic [1:0]       gnt;
    logic [CNT_W:0]   lvl [2];
    logic             sel;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Eligibility: a read may only be issued if the FIFO is guaranteed room
    // when its data arrives, counting the read already in flight and
    // crediting an entry being popped this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            infl[p]  = tag_vld_q & (tag_port_q == 1'(p));
            push[p]  = infl[p];
            pop[p]   = (occ_q[p] != '0) & rsp_ready[p];
            lvl[p]   = {1'b0, occ_q[p]} + (CNT_W + 1)'(infl[p])
                       - (CNT_W + 1)'(pop[p]);
            rd_ok[p] = (lvl[p] < DEPTH_C);
            elig[p]  = req_valid[p] & (req_we[p] | rd_ok[p]);
        end
    end

    // Grant is suppressed while RST is high so the SRAM is deselected
    // immediately, not only after the next edge.
    always_comb begin
        gnt[0] = ~RST & elig[0] & (~elig[1] | ~prio_q);
        gnt[1] = ~RST & elig[1] & (~elig[0] |  prio_q);
    end

    assign sel        = gnt[1];
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (gnt != 2'b00) begin
            sram_ceb = 1'b0;
            sram_web = ~req_we[sel];
            sram_a   = req_addr[sel];
            sram_d   = req_wdata[sel];
        end
    end

    // Next-state for pointer, tag and FIFO bookkeeping.
    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end

        tag_vld_d  = |(gnt & ~req_we);
        tag_port_d = gnt[1];

        for (int p = 0; p < 2; p++) begin
            occ_d[p]    = occ_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            wr_ptr_d[p] = push[p] ? next_ptr(wr_ptr_q[p]) : wr_ptr_q[p];
            rd_ptr_d[p] = pop[p]  ? next_ptr(rd_ptr_q[p]) : rd_ptr_q[p];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q     <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_port_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                occ_q[p]    <= '0;
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
        end else begin
            prio_q     <= prio_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            for (int p = 0; p < 2; p++) begin
                occ_q[p]    <= occ_d[p];
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
            end
        end
    end

    // SRAM Q is captured on the edge after the read edge.
    always_ff @(posedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_q[p][wr_ptr_q[p]] <= sram_q;
            end
        end
    end

    // Read data is forced to zero when empty so reset and idle look clean.
    assign rsp0_valid = (occ_q[0] != '0);
    assign rsp1_valid = (occ_q[1] != '0);
    assign rsp0_rdata = rsp0_valid ? fifo_q[0][rd_ptr_q[0]] : '0;
    assign rsp1_rdata = rsp1_valid ? fifo_q[1][rd_ptr_q[1]] : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Testbench for sram_rr_arbiter: behavioural SRAM model, shadow memory and
// per-port response scoreboards, plus directed checks of grant order,
// latency, backpressure and reset behaviour.

module tb_sram_rr_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int RSP_DEPTH = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_ready;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              sram_ceb, sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    always #5 CLK = ~CLK;

    sram_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Initial contents of an unwritten SRAM word.
    function automatic logic [31:0] pat(input logic [9:0] a);
        return 32'hA500_0000 ^ ({22'd0, a} * 32'h0000_9E37);
    endfunction

    // SRAM macro model: Q registered on a read edge, holds otherwise.
    bit [31:0] sram_mem [1024];
    bit        sram_wr  [1024];
    bit [31:0] sram_q_r;
    always @(posedge CLK) begin
        if (!sram_ceb) begin
            if (!sram_web) begin
                sram_mem[sram_a] <= sram_d;
                sram_wr[sram_a]  <= 1'b1;
            end else begin
                sram_q_r <= sram_wr[sram_a] ? sram_mem[sram_a] : pat(sram_a);
            end
        end
    end
    assign sram_q = sram_q_r;

    // Bench-side reference state.
    logic [31:0] shadow [1024];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    int n_chk = 0;
    int n_err = 0;
    int hs0 = 0, hs1 = 0, pop0_cnt = 0, pop1_cnt = 0;
    int last_g = 2;
    logic last_rdy0, last_rdy1;
    logic [31:0] last_pop1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    // Records handshakes into the scoreboard and checks responses.
    task automatic tick();
        #1;
        last_g    = 2;
        last_rdy0 = req0_ready;
        last_rdy1 = req1_ready;
        chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_valid && req0_ready) begin
            hs0++;
            last_g = 0;
            if (req0_we) shadow[req0_addr] = req0_wdata;
            else         exp0.push_back(shadow[req0_addr]);
        end
        if (req1_valid && req1_ready) begin
            hs1++;
            last_g = 1;
            if (req1_we) shadow[req1_addr] = req1_wdata;
            else         exp1.push_back(shadow[req1_addr]);
        end
        if (rsp0_valid && rsp0_ready) begin
            if (exp0.size() == 0) chk("rsp0_unexpected", {31'd0, rsp0_valid}, 32'd0);
            else                  chk("rsp0_data", rsp0_rdata, exp0.pop_front());
            pop0_cnt++;
        end
        if (rsp1_valid && rsp1_ready) begin
            if (exp1.size() == 0) chk("rsp1_unexpected", {31'd0, rsp1_valid}, 32'd0);
            else                  chk("rsp1_data", rsp1_rdata, exp1.pop_front());
            pop1_cnt++;
            last_pop1 = rsp1_rdata;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, b1;
        for (int i = 0; i < 1024; i++) shadow[i] = pat(10'(i));
        idle_reqs();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset values while RST is held.
        @(negedge CLK);
        chk("rst_rdy0",  {31'd0, req0_ready}, 32'd0);
        chk("rst_rdy1",  {31'd0, req1_ready}, 32'd0);
        chk("rst_rv0",   {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rv1",   {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rd0",   rsp0_rdata, 32'd0);
        chk("rst_rd1",   rsp1_rdata, 32'd0);
        chk("rst_ceb",   {31'd0, sram_ceb}, 32'd1);
        chk("rst_web",   {31'd0, sram_web}, 32'd1);
        chk("rst_a",     {22'd0, sram_a}, 32'd0);
        chk("rst_d",     sram_d, 32'd0);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_ceb", {31'd0, sram_ceb}, 32'd1);
        end

        // Contention: both ports read continuously, grants alternate from 0.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'd2;
        b0 = pop0_cnt; b1 = pop1_cnt;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("cont_gnt", 32'(last_g), 32'(k % 2));
        end
        idle_reqs();
        for (int k = 0; k < 4; k++) tick();
        chk("cont_n0", 32'(pop0_cnt - b0), 32'd3);
        chk("cont_n1", 32'(pop1_cnt - b1), 32'd3);

        // Single port write then read, 2-cycle read latency.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd5; req0_wdata = 32'hDEAD_BEEF;
        tick();
        chk("sp_wr_rdy", {31'd0, last_rdy0}, 32'd1);
        req0_we = 1'b0;
        tick();
        chk("sp_rd_rdy", {31'd0, last_rdy0}, 32'd1);
        req0_valid = 1'b0;
        chk("sp_lat1", {31'd0, rsp0_valid}, 32'd0);
        tick();
        chk("sp_lat2", {31'd0, rsp0_valid}, 32'd1);
        chk("sp_data", rsp0_rdata, 32'hDEAD_BEEF);
        rsp0_ready = 1'b1;
        tick();

        // Backpressure: port 0 reads stall after two, port 1 writes continue.
        rsp0_ready = 1'b0;
        b0 = hs0;
        for (int k = 0; k < 10; k++) begin
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'(200 + k);
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'(300 + k);
            req1_wdata = 32'hB000_0000 + 32'(k);
            tick();
            if (k >= 5) chk("bp_p1_gnt", 32'(last_g), 32'd1);
        end
        chk("bp_hs0", 32'(hs0 - b0), 32'd2);
        chk("bp_rdy0", {31'd0, last_rdy0}, 32'd0);
        chk("bp_rv0", {31'd0, rsp0_valid}, 32'd1);
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        b0 = hs0;
        for (int k = 0; k < 4; k++) begin
            req0_addr = 10'(220 + k);
            tick();
        end
        chk("bp_resume", 32'(hs0 - b0), 32'd4);
        idle_reqs();
        for (int k = 0; k < 5; k++) tick();
        chk("bp_drained", 32'(exp0.size()), 32'd0);
        chk("bp_rv0_end", {31'd0, rsp0_valid}, 32'd0);

        // Cross-port read-after-write at the top address.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd1023; req0_wdata = 32'h1234_5678;
        tick();
        idle_reqs();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'd1023;
        tick();
        idle_reqs();
        for (int k = 0; k < 4; k++) tick();
        chk("raw_data", last_pop1, 32'h1234_5678);
        chk("raw_drained", 32'(exp1.size()), 32'd0);

        // Asynchronous reset with one response queued and one read in flight.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'd7;
        tick();
        req0_addr = 10'd8;
        tick();
        chk("pre_rst_rv0", {31'd0, rsp0_valid}, 32'd1);
        req0_addr = 10'd9;
        #2 RST = 1'b1;
        #1;
        chk("arst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("arst_rv0",  {31'd0, rsp0_valid}, 32'd0);
        chk("arst_rd0",  rsp0_rdata, 32'd0);
        chk("arst_ceb",  {31'd0, sram_ceb}, 32'd1);
        chk("arst_web",  {31'd0, sram_web}, 32'd1);
        chk("arst_a",    {22'd0, sram_a}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        idle_reqs();
        exp0.delete();
        rsp0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_rv0", {31'd0, rsp0_valid}, 32'd0);
            chk("post_rst_ceb", {31'd0, sram_ceb}, 32'd1);
        end
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd10; req0_wdata = 32'h0000_00AA;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'd11; req1_wdata = 32'h0000_00BB;
        tick();
        chk("post_rst_prio", 32'(last_g), 32'd0);
        idle_reqs();
        for (int k = 0; k < 3; k++) tick();
        chk("end_q0", 32'(exp0.size()), 32'd0);
        chk("end_q1", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
